// File: rtl/v_fir.sv
// 21-tap linear-phase raised-cosine pulse-shaping FIR, one sample in and one
// registered sample out per clock; symmetric taps share a single multiplier.
module v_fir #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic signed [IN_W-1:0]  x_in,
    output logic signed [OUT_W-1:0] y_out
);

    localparam int TAPS  = 21;
    localparam int HALF  = 10;
    // Sum of |h| is 657 < 2^10, so IN_W + 10 magnitude bits + sign hold any y.
    localparam int ACC_W = IN_W + 11;

    // Half of the symmetric response: h[k] = h[20-k], centre tap at k = 10.
    localparam logic signed [7:0] H [0:HALF] = '{
        8'sd2, 8'sd3, 8'sd0, -8'sd7, -8'sd15, -8'sd16,
        8'sd0, 8'sd33, 8'sd76, 8'sd113, 8'sd127
    };

    logic signed [IN_W-1:0]  d_q [1:TAPS-1];
    logic signed [IN_W-1:0]  tap [0:TAPS-1];
    logic signed [IN_W:0]    pre;
    logic signed [ACC_W-1:0] acc;
    logic signed [OUT_W-1:0] y_q;
    logic signed [OUT_W-1:0] y_d;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        pre = '0;
        acc = '0;
        tap[0] = x_in;
        for (int k = 1; k < TAPS; k++) begin
            tap[k] = d_q[k];
        end
        // Pre-add mirrored taps: the sum of two IN_W-bit values fits IN_W+1 bits.
        for (int k = 0; k < HALF; k++) begin
            pre = $signed({tap[k][IN_W-1], tap[k]})
                + $signed({tap[TAPS-1-k][IN_W-1], tap[TAPS-1-k]});
            acc = acc + ACC_W'(pre) * ACC_W'(H[k]);
        end
        acc = acc + ACC_W'(tap[HALF]) * ACC_W'(H[HALF]);
        y_d = OUT_W'(acc);
    end

    // NOTE: the delay line is reset along with the output, because a mid-stream
    // reset must leave no trace of pre-reset samples in later outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            y_q <= '0;
            for (int k = 1; k < TAPS; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates let every stage shift from its pre-edge neighbour.
            y_q    <= y_d;
            d_q[1] <= x_in;
            for (int k = 2; k < TAPS; k++) begin
                d_q[k] <= d_q[k-1];
            end
        end
    end

    assign y_out = y_q;

endmodule

// File: tb/tb_v_fir.sv
// Self-checking bench for v_fir: directed vector tables, reset sequences, and
// random 8-PAM traffic against a queue-based convolution model.
module tb_v_fir;

    localparam int IN_W  = 4;
    localparam int OUT_W = 16;

    logic                    clk = 1'b0;
    logic                    nrst;
    logic signed [IN_W-1:0]  x_in;
    logic signed [OUT_W-1:0] y_out;

    always #5 clk = ~clk;

    v_fir #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk  (clk),
        .nrst (nrst),
        .x_in (x_in),
        .y_out(y_out)
    );

    int n_vec = 0;
    int n_bad = 0;

    int h_ref [21] = '{2, 3, 0, -7, -15, -16, 0, 33, 76, 113, 127,
                       113, 76, 33, 0, -16, -15, -7, 0, 3, 2};

    typedef struct {
        int x;
        int exp;
        int grp;
    } vec_t;

    vec_t  tbl [$];
    string grp_name [5] = '{"impulse", "neg_impulse", "dc_pos", "dc_neg", "drain"};

    // Previous 20 input samples, most recent first.
    int hist [$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        for (int k = 0; k < 20; k++) hist.push_back(0);
    endfunction

    function automatic int model_step(input int x);
        int sum;
        sum = h_ref[0] * x;
        for (int k = 1; k < 21; k++) sum += h_ref[k] * hist[k-1];
        hist.push_front(x);
        void'(hist.pop_back());
        return sum;
    endfunction

    function automatic int psum(input int lo, input int hi);
        int s;
        s = 0;
        for (int k = lo; k <= hi && k < 21; k++) s += h_ref[k];
        return s;
    endfunction

    function automatic void add_vec(input int x, input int exp, input int grp);
        vec_t v;
        v.x   = x;
        v.exp = exp;
        v.grp = grp;
        tbl.push_back(v);
    endfunction

    // Drive x_in at the falling edge, sample y_out just after the next rising edge.
    task automatic step(input int x, output int y);
        @(negedge clk);
        x_in = IN_W'(x);
        @(posedge clk);
        #1;
        y = y_out;
    endtask

    initial begin
        int y;
        int cs;
        int sym;
        int sym_hist [$];

        nrst = 1'b0;
        x_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", y_out, 0);
        @(negedge clk);
        nrst = 1'b1;

        // Directed tables: expected values come straight from the tap list.
        for (int j = 0; j < 22; j++) add_vec(j == 0 ? 1 : 0, j <= 20 ? h_ref[j] : 0, 0);
        for (int j = 0; j < 22; j++) add_vec(j == 0 ? -8 : 0, j <= 20 ? -8 * h_ref[j] : 0, 1);
        for (int j = 0; j < 25; j++) add_vec(7, 7 * psum(0, j), 2);
        for (int j = 0; j < 25; j++) add_vec(-7, -7 * psum(0, j) + 7 * psum(j + 1, 20), 3);
        for (int j = 0; j < 22; j++) add_vec(0, -7 * psum(j + 1, 20), 4);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].x, y);
            check(grp_name[tbl[i].grp], y, tbl[i].exp);
            if (tbl[i].grp == 1 && i == 32) check("neg_peak", y, -1016);
            if (tbl[i].grp == 2 && i == 68) check("dc_pos_settled", y, 3535);
            if (tbl[i].grp == 3 && i == 93) check("dc_neg_settled", y, -3535);
        end

        // Asynchronous reset in the middle of a cycle with live history.
        step(7, y);
        step(-3, y);
        step(5, y);
        #2;
        nrst = 1'b0;
        #1;
        check("async_reset", y_out, 0);
        x_in = IN_W'(5);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", y_out, 0);
        end
        @(negedge clk);
        x_in = '0;
        nrst = 1'b1;
        for (int j = 0; j < 22; j++) begin
            step(0, y);
            check("post_reset_zero", y, 0);
        end

        // Random 8-PAM traffic with one reset pulse in the middle.
        model_reset();
        cs = 0;
        for (int c = 0; c < 10000; c++) begin
            if (c == 5000) begin
                @(negedge clk);
                nrst = 1'b0;
                x_in = IN_W'($urandom_range(0, 15));
                #1;
                check("stream_reset", y_out, 0);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    check("stream_reset_hold", y_out, 0);
                end
                @(negedge clk);
                x_in = '0;
                nrst = 1'b1;
                model_reset();
                sym_hist.delete();
                @(posedge clk);
                #1;
                check("stream_release", y_out, model_step(0));
                sym_hist.push_back(0);
                cs = 1;
            end
            sym = (cs % 4 == 0) ? 2 * int'($urandom_range(0, 7)) - 7 : 0;
            sym_hist.push_back(sym);
            step(sym, y);
            check("random_stream", y, model_step(sym));
            if (cs >= 10 && (cs - 10) % 4 == 0 && sym_hist[cs - 10] != 0)
                check("symbol_centre", y, 127 * sym_hist[cs - 10]);
            cs++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
